// File: rtl/elevator_pkg.sv
// Shared command encodings, FSM state type and the LOOK decision rule
// used by the elevator dispatcher.
package elevator_pkg;

    localparam logic [1:0] CMD_IDLE  = 2'b00;
    localparam logic [1:0] CMD_UP    = 2'b01;
    localparam logic [1:0] CMD_DOWN  = 2'b10;
    localparam logic [1:0] CMD_SERVE = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MOVE,
        ST_SERVE,
        ST_CLOSE,
        ST_FAULT
    } state_t;

    typedef struct packed {
        logic [1:0] cmd;
        logic       dir_up;
    } decision_t;

    // LOOK rule: serve here first, keep sweeping up while there is work above,
    // otherwise turn toward whatever remains.
    function automatic decision_t decide(input logic here_req,
                                         input logic any_above,
                                         input logic any_below,
                                         input logic dir_up);
        decision_t d;
        d.cmd    = CMD_IDLE;
        d.dir_up = dir_up;
        if (here_req) begin
            d.cmd = CMD_SERVE;
        end else if (dir_up && any_above) begin
            d.cmd = CMD_UP;
        end else if (any_below) begin
            d.cmd    = CMD_DOWN;
            d.dir_up = 1'b0;
        end else if (any_above) begin
            d.cmd    = CMD_UP;
            d.dir_up = 1'b1;
        end
        return d;
    endfunction

endpackage

// File: rtl/elevator_dispatch_if.sv
// Dispatcher <-> car body bus: call requests and body status in, command and status out.
interface elevator_dispatch_if #(
    parameter int N_FLOORS   = 4,
    parameter int FLOOR_BITS = $clog2(N_FLOORS)
);
    logic [N_FLOORS-1:0]   call_req;
    logic [FLOOR_BITS-1:0] cur_floor;
    logic                  serve_completing;
    logic                  served_pulse;
    logic [1:0]            command;
    logic [N_FLOORS-1:0]   pending;
    logic                  dir_up;
    logic                  busy;
    logic                  fault;

    modport master (
        input  call_req, cur_floor, serve_completing, served_pulse,
        output command, pending, dir_up, busy, fault
    );

    modport slave (
        output call_req, cur_floor, serve_completing, served_pulse,
        input  command, pending, dir_up, busy, fault
    );
endinterface

// File: rtl/elevator_req_scan.sv
// Combinational scan of the pending-request vector relative to the car position.
// An out-of-range cur_floor sees nothing here and nothing above.
module elevator_req_scan #(
    parameter int N_FLOORS   = 4,
    parameter int FLOOR_BITS = $clog2(N_FLOORS)
) (
    input  logic [N_FLOORS-1:0]   pending,
    input  logic [FLOOR_BITS-1:0] cur_floor,
    output logic                  here_req,
    output logic                  any_above,
    output logic                  any_below
);

    logic [31:0] floor_ext;

    assign floor_ext = 32'(cur_floor);

    always_comb begin
        here_req  = 1'b0;
        any_above = 1'b0;
        any_below = 1'b0;
        for (int i = 0; i < N_FLOORS; i++) begin
            if (pending[i]) begin
                if (32'(i) == floor_ext) here_req = 1'b1;
                if (32'(i) > floor_ext)  any_above = 1'b1;
                if (32'(i) < floor_ext)  any_below = 1'b1;
            end
        end
    end

endmodule

// File: rtl/elevator_dispatch.sv
// LOOK-scheduling command generator for one elevator car, with request latching
// and a watchdog that parks the controller in FAULT if the car stops advancing.
module elevator_dispatch
    import elevator_pkg::*;
#(
    parameter int N_FLOORS       = 4,
    parameter int FLOOR_BITS     = $clog2(N_FLOORS),
    parameter int TIMEOUT_CYCLES = 128
) (
    input logic                  clk,
    input logic                  rst_n,
    elevator_dispatch_if.master  bus
);

    localparam int WDOG_BITS = $clog2(TIMEOUT_CYCLES + 1);

    state_t                state, state_nxt;
    logic [1:0]            cmd_q, cmd_nxt;
    logic                  dir_q, dir_nxt;
    logic [N_FLOORS-1:0]   pending_q, clr_mask;
    logic [FLOOR_BITS-1:0] prev_floor;
    logic [WDOG_BITS-1:0]  wdog, wdog_nxt;
    logic                  here_req, any_above, any_below, floor_changed;
    decision_t             dec;

    elevator_req_scan #(
        .N_FLOORS  (N_FLOORS),
        .FLOOR_BITS(FLOOR_BITS)
    ) u_scan (
        .pending  (pending_q),
        .cur_floor(bus.cur_floor),
        .here_req (here_req),
        .any_above(any_above),
        .any_below(any_below)
    );

    assign dec           = decide(here_req, any_above, any_below, dir_q);
    assign floor_changed = (bus.cur_floor != prev_floor);

    // A new call in the same cycle as its clear wins, so that floor is served again.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cmd_q      <= CMD_IDLE;
            dir_q      <= 1'b1;
            pending_q  <= '0;
            prev_floor <= '0;
            wdog       <= '0;
        end else begin
            state      <= state_nxt;
            cmd_q      <= cmd_nxt;
            dir_q      <= dir_nxt;
            pending_q  <= (pending_q & ~clr_mask) | bus.call_req;
            prev_floor <= bus.cur_floor;
            wdog       <= wdog_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cmd_nxt   = cmd_q;
        dir_nxt   = dir_q;
        wdog_nxt  = '0;
        clr_mask  = '0;
        case (state)
            ST_IDLE: begin
                cmd_nxt = CMD_IDLE;
                if (pending_q != '0) begin
                    cmd_nxt = dec.cmd;
                    dir_nxt = dec.dir_up;
                    case (dec.cmd)
                        CMD_SERVE:       state_nxt = ST_SERVE;
                        CMD_UP, CMD_DOWN: state_nxt = ST_MOVE;
                        default:         state_nxt = ST_IDLE;
                    endcase
                end
            end
            ST_MOVE: begin
                wdog_nxt = wdog + WDOG_BITS'(1);
                if (floor_changed) begin
                    wdog_nxt = '0;
                    cmd_nxt  = dec.cmd;
                    dir_nxt  = dec.dir_up;
                    case (dec.cmd)
                        CMD_SERVE: state_nxt = ST_SERVE;
                        CMD_IDLE:  state_nxt = ST_IDLE;
                        default:   state_nxt = ST_MOVE;
                    endcase
                end else if (wdog >= WDOG_BITS'(TIMEOUT_CYCLES)) begin
                    state_nxt = ST_FAULT;
                    cmd_nxt   = CMD_IDLE;
                    wdog_nxt  = '0;
                end
            end
            // Dropping SERVE on serve_completing keeps the body from reopening the doors.
            ST_SERVE: begin
                cmd_nxt = CMD_SERVE;
                if (bus.serve_completing) begin
                    cmd_nxt   = CMD_IDLE;
                    state_nxt = ST_CLOSE;
                    for (int i = 0; i < N_FLOORS; i++) begin
                        if (32'(i) == 32'(bus.cur_floor)) clr_mask[i] = 1'b1;
                    end
                end
            end
            ST_CLOSE: begin
                cmd_nxt = CMD_IDLE;
                if (bus.served_pulse) state_nxt = ST_IDLE;
            end
            ST_FAULT: begin
                cmd_nxt = CMD_IDLE;
            end
            default: begin
                cmd_nxt   = CMD_IDLE;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign bus.command = cmd_q;
    assign bus.pending = pending_q;
    assign bus.dir_up  = dir_q;
    assign bus.busy    = (state != ST_IDLE);
    assign bus.fault   = (state == ST_FAULT);

endmodule

// File: tb/tb_elevator_dispatch.sv
// Scoreboard bench for elevator_dispatch with a simple behavioural car body
// (MOVE_CYCLES per floor, DOOR_CYCLES door dwell).
module tb_elevator_dispatch;
    import elevator_pkg::*;

    localparam int N_FLOORS       = 4;
    localparam int FLOOR_BITS     = 2;
    localparam int TIMEOUT_CYCLES = 128;
    localparam int MOVE_CYCLES    = 50;
    localparam int DOOR_CYCLES    = 40;

    typedef struct packed {
        logic [1:0]            cmd;
        logic [FLOOR_BITS-1:0] floor;
        logic                  dir;
    } ev_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    logic [N_FLOORS-1:0] stim_req    = '0;
    logic [N_FLOORS-1:0] inject_req  = '0;
    logic [N_FLOORS-1:0] inject_mask = '0;
    bit                  inject_armed = 1'b0;
    bit                  freeze       = 1'b0;
    int                  mv_cnt       = 0;
    int                  door_cnt     = 0;
    bit                  pend_served  = 1'b0;

    int  checks = 0;
    int  errors = 0;
    ev_t exp_q[$];

    elevator_dispatch_if #(.N_FLOORS(N_FLOORS)) bus ();

    elevator_dispatch #(
        .N_FLOORS      (N_FLOORS),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    assign bus.call_req = stim_req | inject_req;

    // Car body: moves one floor per MOVE_CYCLES of UP/DOWN, completes a serve after
    // DOOR_CYCLES of SERVE, then emits served_pulse once the command drops.
    always @(negedge clk) begin
        bus.serve_completing = 1'b0;
        bus.served_pulse     = 1'b0;
        inject_req           = '0;
        if (!rst_n) begin
            bus.cur_floor = '0;
            mv_cnt        = 0;
            door_cnt      = 0;
            pend_served   = 1'b0;
        end else begin
            case (bus.command)
                CMD_UP, CMD_DOWN: begin
                    door_cnt = 0;
                    if (!freeze) begin
                        mv_cnt++;
                        if (mv_cnt == MOVE_CYCLES) begin
                            mv_cnt = 0;
                            if (bus.command == CMD_UP) bus.cur_floor = bus.cur_floor + 1'b1;
                            else                       bus.cur_floor = bus.cur_floor - 1'b1;
                        end
                    end
                end
                CMD_SERVE: begin
                    mv_cnt = 0;
                    door_cnt++;
                    if (door_cnt == DOOR_CYCLES) begin
                        door_cnt             = 0;
                        bus.serve_completing = 1'b1;
                        pend_served          = 1'b1;
                        if (inject_armed) inject_req = inject_mask;
                    end
                end
                default: begin
                    mv_cnt   = 0;
                    door_cnt = 0;
                    if (pend_served) begin
                        bus.served_pulse = 1'b1;
                        pend_served      = 1'b0;
                    end
                end
            endcase
        end
    end

    task automatic monitor_loop();
        logic [1:0] last_cmd;
        ev_t        got, e;
        last_cmd = CMD_IDLE;
        forever begin
            @(posedge clk);
            #1;
            if (bus.command !== last_cmd) begin
                last_cmd = bus.command;
                got      = '{cmd: bus.command, floor: bus.cur_floor, dir: bus.dir_up};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_cmd: got cmd=%0d floor=%0d dir=%0b, required no change",
                             got.cmd, got.floor, got.dir);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin
                        errors++;
                        $display("[TB] FAIL cmd_event: got cmd=%0d floor=%0d dir=%0b, required cmd=%0d floor=%0d dir=%0b",
                                 got.cmd, got.floor, got.dir, e.cmd, e.floor, e.dir);
                    end
                end
            end
        end
    endtask

    task automatic expect_ev(input logic [1:0] cmd, input int floor, input logic dir);
        exp_q.push_back('{cmd: cmd, floor: FLOOR_BITS'(floor), dir: dir});
    endtask

    task automatic apply_stimulus(input logic [N_FLOORS-1:0] mask);
        @(negedge clk);
        stim_req = mask;
        @(negedge clk);
        stim_req = '0;
    endtask

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_done(input string name, input int max_cycles);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #2;
            n++;
        end while (!(bus.busy == 1'b0 && exp_q.size() == 0) && n < max_cycles);
        checks++;
        if (bus.busy !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL %s_timeout: busy=%0b queued=%0d, required busy=0 queued=0",
                     name, bus.busy, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic wait_cmd(input string name, input logic [1:0] cmd, input int max_cycles);
        int n;
        n = 0;
        while (bus.command !== cmd && n < max_cycles) begin
            @(posedge clk);
            #2;
            n++;
        end
        check_output(name, 32'(bus.command), 32'(cmd));
    endtask

    initial begin
        int n;
        fork
            monitor_loop();
        join_none

        repeat (3) @(negedge clk);
        check_output("rst_command", 32'(bus.command), 32'(CMD_IDLE));
        check_output("rst_pending", 32'(bus.pending), 32'h0);
        check_output("rst_dir_up",  32'(bus.dir_up),  32'h1);
        check_output("rst_fault",   32'(bus.fault),   32'h0);
        check_output("rst_busy",    32'(bus.busy),    32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] call at current floor 0");
        expect_ev(CMD_SERVE, 0, 1'b1);
        expect_ev(CMD_IDLE,  0, 1'b1);
        apply_stimulus(4'b0001);
        wait_done("here_serve", 400);
        check_output("here_pending", 32'(bus.pending), 32'h0);
        repeat (10) @(negedge clk);

        $display("[TB] call floor 2 from floor 0");
        expect_ev(CMD_UP,    0, 1'b1);
        expect_ev(CMD_SERVE, 2, 1'b1);
        expect_ev(CMD_IDLE,  2, 1'b1);
        apply_stimulus(4'b0100);
        wait_done("up_two", 600);
        check_output("up_two_pending", 32'(bus.pending), 32'h0);
        check_output("up_two_dir",     32'(bus.dir_up),  32'h1);

        $display("[TB] reverse from floor 2 to floor 0");
        expect_ev(CMD_DOWN,  2, 1'b0);
        expect_ev(CMD_SERVE, 0, 1'b0);
        expect_ev(CMD_IDLE,  0, 1'b0);
        apply_stimulus(4'b0001);
        wait_done("down_rev", 600);
        check_output("down_rev_pending", 32'(bus.pending), 32'h0);
        check_output("down_rev_dir",     32'(bus.dir_up),  32'h0);

        $display("[TB] recall of current floor during serve completion");
        expect_ev(CMD_SERVE, 0, 1'b0);
        expect_ev(CMD_IDLE,  0, 1'b0);
        expect_ev(CMD_SERVE, 0, 1'b0);
        expect_ev(CMD_IDLE,  0, 1'b0);
        inject_mask  = 4'b0001;
        inject_armed = 1'b1;
        apply_stimulus(4'b0001);
        n = 0;
        do begin
            @(posedge clk);
            n++;
        end while (bus.serve_completing !== 1'b1 && n < 200);
        #2;
        check_output("recall_pending_bit", 32'(bus.pending[0]), 32'h1);
        inject_armed = 1'b0;
        wait_done("recall", 400);
        check_output("recall_pending", 32'(bus.pending), 32'h0);

        $display("[TB] frozen car trips the watchdog");
        freeze = 1'b1;
        expect_ev(CMD_UP,   0, 1'b1);
        expect_ev(CMD_IDLE, 0, 1'b1);
        apply_stimulus(4'b0100);
        wait_cmd("wdog_up", CMD_UP, 10);
        n = 0;
        while (bus.fault !== 1'b1 && n < 400) begin
            @(posedge clk);
            #2;
            n++;
        end
        checks++;
        if (n < TIMEOUT_CYCLES - 1 || n > TIMEOUT_CYCLES + 2) begin
            errors++;
            $display("[TB] FAIL wdog_latency: got %0d cycles, required %0d..%0d",
                     n, TIMEOUT_CYCLES - 1, TIMEOUT_CYCLES + 2);
        end
        repeat (20) @(posedge clk);
        #2;
        check_output("fault_sticky",  32'(bus.fault),   32'h1);
        check_output("fault_command", 32'(bus.command), 32'(CMD_IDLE));
        check_output("fault_busy",    32'(bus.busy),    32'h1);
        apply_stimulus(4'b0010);
        @(posedge clk);
        #2;
        check_output("fault_latch", 32'(bus.pending), 32'b0110);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_output("areset_fault",   32'(bus.fault),   32'h0);
        check_output("areset_command", 32'(bus.command), 32'(CMD_IDLE));
        check_output("areset_pending", 32'(bus.pending), 32'h0);
        check_output("areset_dir_up",  32'(bus.dir_up),  32'h1);
        check_output("areset_busy",    32'(bus.busy),    32'h0);
        repeat (2) @(negedge clk);
        freeze = 1'b0;
        rst_n  = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] up sweep with a mid-move call below the target");
        expect_ev(CMD_UP,    0, 1'b1);
        expect_ev(CMD_SERVE, 1, 1'b1);
        expect_ev(CMD_IDLE,  1, 1'b1);
        expect_ev(CMD_UP,    1, 1'b1);
        expect_ev(CMD_SERVE, 3, 1'b1);
        expect_ev(CMD_IDLE,  3, 1'b1);
        apply_stimulus(4'b1000);
        wait_cmd("sweep_up", CMD_UP, 10);
        repeat (10) @(negedge clk);
        stim_req = 4'b0010;
        @(negedge clk);
        stim_req = '0;
        wait_done("sweep", 1000);
        check_output("sweep_pending", 32'(bus.pending), 32'h0);
        check_output("sweep_dir",     32'(bus.dir_up),  32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
